// File: rtl/ov7670_cfg_pkg.sv
// ---------------------------------------------------------------------------
// ov7670_cfg_pkg
//
// Shared definitions for the OV7670 configuration sequencer:
//   - state_t            : sequencer FSM state encoding
//   - DELAY_W            : width of the delay counter
//   - DEFAULT_DELAY_CYC  : default clocks waited per delay marker
//   - end_code(dw)       : in-band end-of-table marker (all ones)
//   - delay_code(dw)     : in-band delay marker (all ones, low nibble clear)
//
// Both marker functions return a MAX_DW-wide vector. The caller casts the
// result down to its own ROM word width.
// ---------------------------------------------------------------------------
package ov7670_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_ROM  = 3'd2,
        S_DECODE    = 3'd3,
        S_REQ       = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_DELAY     = 3'd6,
        S_FINISH    = 3'd7
    } state_t;

    localparam int                 DELAY_W           = 20;
    localparam logic [DELAY_W-1:0] DEFAULT_DELAY_CYC = 20'd1_000_000;

    // Widest ROM word the marker helpers support.
    localparam int MAX_DW = 64;

    // All ones across the low dw bits.
    function automatic logic [MAX_DW-1:0] end_code(input int dw);
        logic [MAX_DW-1:0] code;
        code = '0;
        for (int i = 0; i < MAX_DW; i++) begin
            if (i < dw) code[i] = 1'b1;
        end
        return code;
    endfunction

    // End marker with the low 4 bits cleared.
    function automatic logic [MAX_DW-1:0] delay_code(input int dw);
        return end_code(dw) & {{(MAX_DW-4){1'b1}}, 4'h0};
    endfunction

endpackage

// File: rtl/ov7670_cfg_delay.sv
// ---------------------------------------------------------------------------
// ov7670_cfg_delay
//
// Loadable down-counter with a zero flag. A load takes priority over a
// decrement. The counter saturates at zero, so holding en high after it
// expires is harmless.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset (clears the count)
//   load      in   load load_val on the next edge
//   load_val  in   value to load (W bits)
//   en        in   decrement enable
//   zero      out  count == 0
// ---------------------------------------------------------------------------
module ov7670_cfg_delay #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its inputs regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ov7670_config_seq.sv
// ---------------------------------------------------------------------------
// ov7670_config_seq
//
// Configuration sequencer for OV7670-class sensors. Walks a synchronous
// register/value ROM from address 0. Each ordinary word {reg, val} becomes
// one write command to the SCCB master. Two in-band markers are recognised:
//   all ones                 -> end of table
//   all ones, low nibble 0   -> wait DELAY_CYC clocks, then continue
// A NACKed write is re-sent up to MAX_RETRY times. After that the sequence
// stops with err set and err_addr holding the failing ROM index. Running
// off the end of the table without a marker ends the sequence normally.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse, accepted only when idle
//   rom_en / rom_addr   ROM read strobe and index
//   rom_data            ROM word, valid ROM_LAT cycles after rom_en
//   cmd_valid/ready     write command handshake to the SCCB master
//   cmd_reg / cmd_val   register address / value, stable while valid
//   cmd_done / cmd_nack transfer finished pulse and its NACK status
//   busy                sequence in progress
//   done / err          sticky completion / failure flags until next start
//   err_addr            ROM index of the entry that exhausted its retries
// ---------------------------------------------------------------------------
module ov7670_config_seq
    import ov7670_cfg_pkg::*;
#(
    parameter int                 ADDR_W    = 8,
    parameter int                 REG_W     = 8,
    parameter int                 VAL_W     = 8,
    parameter int                 ROM_LAT   = 1,
    parameter logic [DELAY_W-1:0] DELAY_CYC = DEFAULT_DELAY_CYC,
    parameter int                 MAX_RETRY = 3,
    localparam int                DW        = REG_W + VAL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DW-1:0]     rom_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [REG_W-1:0]  cmd_reg,
    output logic [VAL_W-1:0]  cmd_val,
    input  logic              cmd_done,
    input  logic              cmd_nack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [DW-1:0]      END_CODE    = DW'(end_code(DW));
    localparam logic [DW-1:0]      DELAY_CODE  = DW'(delay_code(DW));
    localparam logic [1:0]         LAT_LAST    = 2'(ROM_LAT - 1);
    localparam logic [3:0]         RETRY_LIMIT = 4'(MAX_RETRY);
    localparam logic [DELAY_W-1:0] DELAY_LOAD  = DELAY_CYC - DELAY_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        lat_cnt;
    logic [DW-1:0]     rom_word;
    logic [3:0]        retry_cnt;
    logic              is_end;
    logic              is_delay;
    logic              at_last;
    logic              dly_load;
    logic              dly_en;
    logic              dly_zero;

    assign is_end   = (rom_word == END_CODE);
    assign is_delay = (rom_word == DELAY_CODE);
    assign at_last  = (rom_addr == {ADDR_W{1'b1}});

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: state_nxt gets a default before the case so every path assigns
    // it; without that, a missed branch would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = S_FETCH;
            S_FETCH:    state_nxt = S_WAIT_ROM;
            S_WAIT_ROM: if (lat_cnt == LAT_LAST) state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_end)        state_nxt = S_FINISH;
                else if (is_delay) state_nxt = S_DELAY;
                else               state_nxt = S_REQ;
            end
            S_REQ:      if (cmd_ready) state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (cmd_done) begin
                    if (!cmd_nack)                   state_nxt = at_last ? S_FINISH : S_FETCH;
                    else if (retry_cnt < RETRY_LIMIT) state_nxt = S_REQ;
                    else                             state_nxt = S_FINISH;
                end
            end
            S_DELAY:    if (dly_zero) state_nxt = at_last ? S_FINISH : S_FETCH;
            S_FINISH:   state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / control decode
    // -----------------------------------------------------------------------
    // These outputs decode the state register directly, so an asynchronous
    // reset drops cmd_valid and busy immediately.
    always_comb begin
        rom_en    = (state == S_FETCH);
        cmd_valid = (state == S_REQ);
        busy      = (state != S_IDLE) && (state != S_FINISH);
        dly_load  = (state == S_DECODE) && !is_end && is_delay;
        dly_en    = (state == S_DELAY);
    end

    // -----------------------------------------------------------------------
    // Datapath: ROM index, captured word, command, retry and status
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr  <= '0;
            lat_cnt   <= '0;
            rom_word  <= '0;
            cmd_reg   <= '0;
            cmd_val   <= '0;
            retry_cnt <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_addr  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rom_addr  <= '0;
                        retry_cnt <= '0;
                        done      <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                S_FETCH: lat_cnt <= '0;
                S_WAIT_ROM: begin
                    lat_cnt <= lat_cnt + 2'd1;
                    if (lat_cnt == LAT_LAST) rom_word <= rom_data;
                end
                S_DECODE: begin
                    if (!is_end && !is_delay) begin
                        cmd_reg <= rom_word[DW-1:VAL_W];
                        cmd_val <= rom_word[VAL_W-1:0];
                    end
                end
                S_WAIT_DONE: begin
                    if (cmd_done) begin
                        if (!cmd_nack) begin
                            retry_cnt <= '0;
                            if (!at_last) rom_addr <= rom_addr + ADDR_W'(1);
                        end else if (retry_cnt < RETRY_LIMIT) begin
                            retry_cnt <= retry_cnt + 4'd1;
                        end else begin
                            err      <= 1'b1;
                            err_addr <= rom_addr;
                        end
                    end
                end
                S_DELAY: begin
                    if (dly_zero && !at_last) rom_addr <= rom_addr + ADDR_W'(1);
                end
                S_FINISH: done <= !err;
                default: ;
            endcase
        end
    end

    // The counter is loaded with DELAY_CYC-1 in DECODE, so DELAY lasts
    // exactly DELAY_CYC cycles (the last one being the cycle it reads zero).
    ov7670_cfg_delay #(
        .W (DELAY_W)
    ) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (dly_load),
        .load_val (DELAY_LOAD),
        .en       (dly_en),
        .zero     (dly_zero)
    );

endmodule

// File: tb/tb_ov7670_config_seq.sv
// ---------------------------------------------------------------------------
// tb_ov7670_config_seq
//
// Directed bench for ov7670_config_seq. It uses a 4-entry ROM (ADDR_W=2),
// ROM_LAT=1, DELAY_CYC=10 and MAX_RETRY=2. A synchronous ROM model and a
// scripted SCCB responder surround the DUT. The responder logs every
// accepted command, every ROM fetch and every cmd_done pulse. All timing
// is measured in posedge counts, with the logs read at negedges.
// ---------------------------------------------------------------------------
module tb_ov7670_config_seq;

    localparam int          ADDR_W    = 2;
    localparam int          REG_W     = 8;
    localparam int          VAL_W     = 8;
    localparam int          DW        = 16;
    localparam int          ROM_LAT   = 1;
    localparam logic [19:0] DELAY_CYC = 20'd10;
    localparam int          MAX_RETRY = 2;
    localparam int          LOG_N     = 32;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DW-1:0]     rom_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [REG_W-1:0]  cmd_reg;
    logic [VAL_W-1:0]  cmd_val;
    logic              cmd_done;
    logic              cmd_nack;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] err_addr;

    int tests_run;
    int tests_failed;

    ov7670_config_seq #(
        .ADDR_W    (ADDR_W),
        .REG_W     (REG_W),
        .VAL_W     (VAL_W),
        .ROM_LAT   (ROM_LAT),
        .DELAY_CYC (DELAY_CYC),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_reg   (cmd_reg),
        .cmd_val   (cmd_val),
        .cmd_done  (cmd_done),
        .cmd_nack  (cmd_nack),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_addr  (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge counter; stable whenever it is read at a negedge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM with one cycle of latency.
    logic [DW-1:0] rom_mem [4];
    always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

    // Responder controls
    int ready_delay;   // cycles cmd_ready stays low while cmd_valid is high
    int done_delay;    // negedges from accept to the cmd_done pulse
    int nack_after;    // successful transfers before NACKs begin
    int nack_left;     // number of NACKs to give after that

    // Logs
    logic [7:0] acc_reg [LOG_N];
    logic [7:0] acc_val [LOG_N];
    int         acc_n;
    int         fetch_addr [LOG_N];
    int         fetch_cyc  [LOG_N];
    int         fetch_n;
    int         done_cyc   [LOG_N];
    int         done_n;
    int         first_valid_cyc;
    int         valid_hi_n;
    int         unstable_n;
    int         start_cyc;

    // SCCB master model and monitor; all activity happens on negedges.
    initial begin
        int         valid_cycles;
        int         done_cnt;
        logic       in_valid;
        logic [7:0] held_reg;
        logic [7:0] held_val;
        cmd_ready    = 1'b0;
        cmd_done     = 1'b0;
        cmd_nack     = 1'b0;
        valid_cycles = 0;
        done_cnt     = 0;
        in_valid     = 1'b0;
        held_reg     = '0;
        held_val     = '0;
        forever begin
            @(negedge clk);
            cmd_done = 1'b0;
            cmd_nack = 1'b0;
            if (!rst_n) begin
                cmd_ready    = 1'b0;
                done_cnt     = 0;
                valid_cycles = 0;
                in_valid     = 1'b0;
            end else begin
                if (rom_en && fetch_n < LOG_N) begin
                    fetch_addr[fetch_n] = int'(rom_addr);
                    fetch_cyc[fetch_n]  = cyc;
                    fetch_n++;
                end
                if (done_cnt > 0) begin
                    done_cnt--;
                    if (done_cnt == 0) begin
                        cmd_done = 1'b1;
                        if (nack_after > 0) nack_after--;
                        else if (nack_left > 0) begin
                            cmd_nack = 1'b1;
                            nack_left--;
                        end
                        if (done_n < LOG_N) begin
                            done_cyc[done_n] = cyc;
                            done_n++;
                        end
                    end
                end
                if (cmd_valid) begin
                    valid_hi_n++;
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                    if (!in_valid) begin
                        held_reg = cmd_reg;
                        held_val = cmd_val;
                        in_valid = 1'b1;
                    end else if (cmd_reg !== held_reg || cmd_val !== held_val) begin
                        unstable_n++;
                    end
                    if (valid_cycles >= ready_delay) begin
                        // valid is high now and stays high to the next edge,
                        // so raising ready here guarantees that edge accepts.
                        cmd_ready = 1'b1;
                        if (acc_n < LOG_N) begin
                            acc_reg[acc_n] = cmd_reg;
                            acc_val[acc_n] = cmd_val;
                        end
                        acc_n++;
                        done_cnt = done_delay;
                    end else begin
                        cmd_ready = 1'b0;
                        valid_cycles++;
                    end
                end else begin
                    cmd_ready    = 1'b0;
                    valid_cycles = 0;
                    in_valid     = 1'b0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t (required: finished)", $time);
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        acc_n           = 0;
        fetch_n         = 0;
        done_n          = 0;
        first_valid_cyc = -1;
        valid_hi_n      = 0;
        unstable_n      = 0;
        ready_delay     = 0;
        done_delay      = 2;
        nack_after      = 0;
        nack_left       = 0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_finish(input int budget, input string name);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, busy, budget);
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests_run++;
        if ({rom_en, rom_addr, cmd_valid, cmd_reg, cmd_val, busy, done, err, err_addr} !== 25'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {rom_en, rom_addr, cmd_valid, cmd_reg, cmd_val, busy, done, err, err_addr});
        end
    endtask

    task automatic test_basic();
        clear_logs();
        rom_mem = '{16'h1280, 16'h1204, 16'hFFFF, 16'h0000};
        do_start();
        wait_finish(200, "basic");
        tests_run++;
        if (acc_n !== 2) begin tests_failed++; $display("FAIL basic_count: got %0d commands, required 2", acc_n); end
        tests_run++;
        if ({acc_reg[0], acc_val[0]} !== 16'h1280) begin tests_failed++; $display("FAIL basic_cmd0: got %h, required 1280", {acc_reg[0], acc_val[0]}); end
        tests_run++;
        if ({acc_reg[1], acc_val[1]} !== 16'h1204) begin tests_failed++; $display("FAIL basic_cmd1: got %h, required 1204", {acc_reg[1], acc_val[1]}); end
        tests_run++;
        if ({done, err, busy} !== 3'b100) begin tests_failed++; $display("FAIL basic_status: done/err/busy got %b, required 100", {done, err, busy}); end
        // start cycle -> FETCH, WAIT_ROM, DECODE, REQ: ROM_LAT + 3 = 4
        tests_run++;
        if (first_valid_cyc - start_cyc !== 4) begin tests_failed++; $display("FAIL basic_latency: got %0d cycles, required 4", first_valid_cyc - start_cyc); end
        tests_run++;
        if (rom_addr !== 2'd2) begin tests_failed++; $display("FAIL basic_rom_addr: got %0d, required 2", rom_addr); end
    endtask

    task automatic test_delay();
        int f2;
        clear_logs();
        rom_mem = '{16'h1280, 16'hFFF0, 16'h1101, 16'hFFFF};
        do_start();
        wait_finish(300, "delay");
        f2 = -1;
        for (int i = 0; i < fetch_n; i++) if (fetch_addr[i] == 2) f2 = fetch_cyc[i];
        // done cycle t0 -> FETCH t0+1, WAIT_ROM t0+2, DECODE t0+3,
        // DELAY t0+4..t0+13 (10 cycles), FETCH of entry 2 at t0+14
        tests_run++;
        if (f2 - done_cyc[0] !== 14) begin tests_failed++; $display("FAIL delay_gap: got %0d cycles, required 14", f2 - done_cyc[0]); end
        tests_run++;
        if (acc_n !== 2 || {acc_reg[1], acc_val[1]} !== 16'h1101) begin
            tests_failed++;
            $display("FAIL delay_cmds: got %0d cmds, last %h, required 2 cmds, last 1101", acc_n, {acc_reg[1], acc_val[1]});
        end
        tests_run++;
        if ({done, err} !== 2'b10) begin tests_failed++; $display("FAIL delay_status: done/err got %b, required 10", {done, err}); end
    endtask

    task automatic test_stall();
        clear_logs();
        ready_delay = 7;
        rom_mem = '{16'h3A5C, 16'hFFFF, 16'h0000, 16'h0000};
        do_start();
        wait_finish(200, "stall");
        // 7 cycles with ready low plus the accepting cycle
        tests_run++;
        if (valid_hi_n !== 8) begin tests_failed++; $display("FAIL stall_valid_cycles: got %0d, required 8", valid_hi_n); end
        tests_run++;
        if (unstable_n !== 0) begin tests_failed++; $display("FAIL stall_stable: got %0d changes, required 0", unstable_n); end
        tests_run++;
        if (acc_n !== 1 || {acc_reg[0], acc_val[0]} !== 16'h3A5C) begin
            tests_failed++;
            $display("FAIL stall_accept: got %0d accepts of %h, required 1 of 3A5C", acc_n, {acc_reg[0], acc_val[0]});
        end
    endtask

    task automatic test_retry();
        int seen2;
        clear_logs();
        nack_after = 1;
        nack_left  = 3;
        rom_mem = '{16'h1280, 16'h1313, 16'h1414, 16'hFFFF};
        do_start();
        wait_finish(300, "retry");
        // one clean write, then 1 + MAX_RETRY attempts of entry 1
        tests_run++;
        if (acc_n !== 4) begin tests_failed++; $display("FAIL retry_attempts: got %0d commands, required 4", acc_n); end
        tests_run++;
        if ({acc_reg[2], acc_val[2], acc_reg[3], acc_val[3]} !== 32'h1313_1313) begin
            tests_failed++;
            $display("FAIL retry_same_data: got %h, required 13131313", {acc_reg[2], acc_val[2], acc_reg[3], acc_val[3]});
        end
        tests_run++;
        if ({err, done, err_addr} !== 4'b10_01) begin tests_failed++; $display("FAIL retry_status: err/done/err_addr got %b, required 1001", {err, done, err_addr}); end
        seen2 = 0;
        for (int i = 0; i < fetch_n; i++) if (fetch_addr[i] == 2) seen2++;
        tests_run++;
        if (seen2 !== 0) begin tests_failed++; $display("FAIL retry_no_fetch2: entry 2 fetched %0d times, required 0", seen2); end
    endtask

    task automatic test_no_end();
        clear_logs();
        rom_mem = '{16'h1001, 16'h2002, 16'h3003, 16'h4004};
        do_start();
        wait_finish(300, "no_end");
        tests_run++;
        if (acc_n !== 4 || {acc_reg[3], acc_val[3]} !== 16'h4004) begin
            tests_failed++;
            $display("FAIL no_end_cmds: got %0d cmds, last %h, required 4, last 4004", acc_n, {acc_reg[3], acc_val[3]});
        end
        tests_run++;
        if (fetch_n !== 4) begin tests_failed++; $display("FAIL no_end_wrap: got %0d fetches, required 4", fetch_n); end
        tests_run++;
        if ({done, err, rom_addr} !== 4'b10_11) begin tests_failed++; $display("FAIL no_end_status: done/err/rom_addr got %b, required 1011", {done, err, rom_addr}); end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_logs();
        done_delay = 6;
        rom_mem = '{16'h1280, 16'h1204, 16'hFFFF, 16'h0000};
        do_start();
        n = 0;
        @(posedge clk); #1;
        while (acc_n < 1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        // First command just accepted: DUT sits in WAIT_DONE.
        tests_run++;
        if ({busy, cmd_valid, cmd_reg} !== 10'b10_0001_0010) begin
            tests_failed++;
            $display("FAIL mid_pre_reset: busy/valid/reg got %b, required 1000010010", {busy, cmd_valid, cmd_reg});
        end
        #2 rst_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        do_start();
        wait_finish(200, "restart");
        tests_run++;
        if (fetch_n < 1 || fetch_addr[0] !== 0) begin tests_failed++; $display("FAIL restart_addr: first fetch %0d, required 0", fetch_addr[0]); end
        tests_run++;
        if (acc_n !== 2 || {acc_reg[0], acc_val[0]} !== 16'h1280) begin
            tests_failed++;
            $display("FAIL restart_cmd: got %0d cmds, first %h, required 2, first 1280", acc_n, {acc_reg[0], acc_val[0]});
        end
        tests_run++;
        if (done !== 1'b1) begin tests_failed++; $display("FAIL restart_done: got %b, required 1", done); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        rom_mem      = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        clear_logs();
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_delay();
        test_stall();
        test_retry();
        test_no_end();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
